pulse_generator: RTL and testbench

- Transmit-side companion to the pulse counter.
- Emits a programmed burst of pulses, each with a configurable high width and low width in clock cycles, then reports completion.
- Drives the pulse input of a counter in system-level loopback tests, and serves as a stimulus source for external pulse-counting logic.

---
 rtl/pulse_generator.sv | 166 ++++++++++++++++
 tb/tb_pulse_generator.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_generator.sv
// Burst pulse generator: emits num_pulses pulses of high_cycles/low_cycles width, then strobes done.
// Optional free-running mode (num_pulses=0) is enabled by defining PULSE_GEN_CONTINUOUS_EN.
module pulse_generator #(
  parameter int CNT_W = 32,
  parameter int WID_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [WID_W-1:0] high_cycles,
  input  logic [WID_W-1:0] low_cycles,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a one-cycle request honoured only when IDLE and abort is low;
  // abort ends a burst in HIGH/LOW on the next edge without a done strobe.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WID_W-1:0] phase_q, phase_d;
  logic [WID_W-1:0] high_q, high_d;
  logic [WID_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cont_w;
  logic             start_ok;
  logic [CNT_W-1:0] sent_inc;

`ifdef PULSE_GEN_CONTINUOUS_EN
  logic cont_q, cont_d;
  assign cont_w   = cont_q;
  assign start_ok = 1'b1;
`else
  assign cont_w   = 1'b0;
  assign start_ok = (num_pulses != '0);
`endif

  assign sent_inc = sent_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    high_d  = high_q;
    low_d   = low_q;
    num_d   = num_q;
    sent_d  = sent_q;
    pulse_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef PULSE_GEN_CONTINUOUS_EN
    cont_d  = cont_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          sent_d = '0;
          if (start_ok) begin
            // Zero widths are stored as 1 so the phase compare never underflows.
            high_d  = (high_cycles == '0) ? WID_W'(1) : high_cycles;
            low_d   = (low_cycles == '0) ? WID_W'(1) : low_cycles;
            num_d   = num_pulses;
`ifdef PULSE_GEN_CONTINUOUS_EN
            cont_d  = (num_pulses == '0);
`endif
            phase_d = '0;
            state_d = S_HIGH;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (phase_q == high_q - WID_W'(1)) begin
          sent_d  = sent_inc;
          phase_d = '0;
          if (!cont_w && sent_inc == num_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOW;
            busy_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + WID_W'(1);
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (phase_q == low_q - WID_W'(1)) begin
          phase_d = '0;
          state_d = S_HIGH;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          phase_d = phase_q + WID_W'(1);
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PULSE_GEN_CONTINUOUS_EN
      cont_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PULSE_GEN_CONTINUOUS_EN
      cont_q  <= cont_d;
`endif
    end
  end

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sent_cnt  = sent_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: timeline model of each burst checked every cycle, plus directed literal checks.
// Continuous-mode scenario is compiled in when PULSE_GEN_CONTINUOUS_EN is defined.
module tb_pulse_generator;
  localparam int CNT_W = 32;
  localparam int WID_W = 16;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_pulses = '0;
  logic [WID_W-1:0] high_cycles = '0;
  logic [WID_W-1:0] low_cycles = '0;
  logic             pulse, busy, done;
  logic [CNT_W-1:0] sent_cnt;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  pulse_generator #(.CNT_W(CNT_W), .WID_W(WID_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_pulses(num_pulses), .high_cycles(high_cycles), .low_cycles(low_cycles),
    .pulse(pulse), .busy(busy), .done(done), .sent_cnt(sent_cnt), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef PULSE_GEN_CONTINUOUS_EN
  localparam bit CONT_BUILD = 1'b1;
`else
  localparam bit CONT_BUILD = 1'b0;
`endif

  // Model: a burst is a timeline measured in edges n since the accepted start edge.
  longint e = 0;
  bit     m_active = 1'b0;
  bit     m_cont = 1'b0;
  longint m_t0, m_n, m_h, m_l, m_end;
  longint m_hold = 0;
  logic             exp_pulse = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic [CNT_W-1:0] exp_sent = '0;

  function automatic longint m_count(input longint n);
    longint c;
    if (n < m_h) return 0;
    c = (n - m_h) / (m_h + m_l) + 1;
    if (!m_cont && c > m_n) c = m_n;
    return c;
  endfunction

  task automatic set_idle();
    exp_pulse = 1'b0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    exp_sent  = CNT_W'(m_hold);
  endtask

  task automatic model_step();
    longint n;
    e++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_hold   = 0;
      set_idle();
      return;
    end
    if (!m_active && start && !abort) begin
      m_active = 1'b1;
      m_t0     = e;
      m_n      = longint'(num_pulses);
      m_h      = (high_cycles == 0) ? 1 : longint'(high_cycles);
      m_l      = (low_cycles == 0) ? 1 : longint'(low_cycles);
      m_cont   = CONT_BUILD && (num_pulses == 0);
      if (m_cont) m_end = 64'h3fff_ffff_ffff_ffff;
      else if (m_n == 0) m_end = 0;
      else m_end = m_n * (m_h + m_l) - m_l;
    end
    if (!m_active) begin
      set_idle();
      return;
    end
    n = e - m_t0;
    if (abort && n >= 1 && n <= m_end) begin
      m_active = 1'b0;
      m_hold   = m_count(n - 1);
      set_idle();
    end else if (n < m_end) begin
      exp_busy  = 1'b1;
      exp_done  = 1'b0;
      exp_pulse = ((n % (m_h + m_l)) < m_h);
      exp_sent  = CNT_W'(m_count(n));
    end else if (n == m_end) begin
      exp_busy  = 1'b0;
      exp_pulse = 1'b0;
      exp_done  = 1'b1;
      exp_sent  = CNT_W'(m_count(n));
    end else begin
      m_active = 1'b0;
      m_hold   = m_n;
      set_idle();
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process and observation counters (sampled on the falling edge).
  int  cyc = 0, rises = 0, busy_cyc = 0, hi_cyc = 0, done_cnt = 0;
  int  start_cyc = -1, first_hi_cyc = -1, last_hi_cyc = -1, done_cyc = -1;
  logic prev_pulse = 1'b0;

  task automatic clear_mon();
    rises = 0; busy_cyc = 0; hi_cyc = 0; done_cnt = 0;
    start_cyc = -1; first_hi_cyc = -1; last_hi_cyc = -1; done_cyc = -1;
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    check("pulse", pulse, exp_pulse);
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("sent_cnt", sent_cnt, exp_sent);
    if (start && !busy && start_cyc < 0) start_cyc = cyc;
    if (pulse && !prev_pulse) rises++;
    if (pulse) begin
      hi_cyc++;
      last_hi_cyc = cyc;
      if (first_hi_cyc < 0) first_hi_cyc = cyc;
    end
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_pulse = pulse;
  end

  // driver tasks
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input int h, input int l);
    num_pulses  = CNT_W'(n);
    high_cycles = WID_W'(h);
    low_cycles  = WID_W'(l);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    num_pulses  = $urandom;
    high_cycles = WID_W'($urandom);
    low_cycles  = WID_W'($urandom);
  endtask

  task automatic wait_end(input int max_cyc);
    bit ended = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && !done) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) check("wait_end_timeout", 1, 0);
    tick(1);
  endtask

  task automatic wait_rises(input int target, input int max_cyc);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rises >= target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("wait_rises_timeout", 1, 0);
  endtask

  initial begin
    // reset then idle
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("reset_sent", sent_cnt, 0);
    check("reset_busy", busy, 0);

    // basic burst N=4 H=3 L=5
    clear_mon();
    do_start(4, 3, 5);
    wait_end(200);
    check("basic_busy_cycles", busy_cyc, 27);
    check("basic_high_cycles", hi_cyc, 12);
    check("basic_rises", rises, 4);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_latency", first_hi_cyc - start_cyc, 1);
    check("basic_done_after_last_high", done_cyc - last_hi_cyc, 1);
    check("basic_sent", sent_cnt, 4);

    // zero widths, then zero count
    clear_mon();
    do_start(2, 0, 0);
    wait_end(50);
    check("zw_busy_cycles", busy_cyc, 3);
    check("zw_rises", rises, 2);
    check("zw_sent", sent_cnt, 2);
    if (!CONT_BUILD) begin
      clear_mon();
      do_start(0, 3, 3);
      wait_end(50);
      check("zero_done_cnt", done_cnt, 1);
      check("zero_rises", rises, 0);
      check("zero_done_latency", done_cyc - start_cyc, 1);
      check("zero_sent", sent_cnt, 0);
    end

    // abort during the 2nd high phase
    clear_mon();
    do_start(10, 4, 4);
    wait_rises(2, 100);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    check("abort_pulse", pulse, 0);
    check("abort_busy", busy, 0);
    check("abort_sent", sent_cnt, 1);
    tick(5);
    check("abort_no_done", done_cnt, 0);

    // start and abort together in IDLE
    clear_mon();
    num_pulses = 5; high_cycles = 2; low_cycles = 2;
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(6);
    check("start_abort_busy_cycles", busy_cyc, 0);
    check("start_abort_sent", sent_cnt, 1);

    // start while busy is ignored
    clear_mon();
    do_start(3, 2, 2);
    tick(3);
    num_pulses = 1; high_cycles = 9; low_cycles = 9;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_end(100);
    check("busy_start_rises", rises, 3);
    check("busy_start_sent", sent_cnt, 3);

    // reset during a LOW phase, then a fresh burst
    clear_mon();
    do_start(5, 3, 6);
    wait_rises(1, 50);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!pulse) break;
    end
    tick(1);
    rst_n = 1'b0;
    tick(1);
    @(negedge clk);
    check("rst_low_pulse", pulse, 0);
    check("rst_low_busy", busy, 0);
    check("rst_low_sent", sent_cnt, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    clear_mon();
    do_start(2, 1, 1);
    wait_end(50);
    check("after_rst_sent", sent_cnt, 2);
    check("after_rst_rises", rises, 2);

    // loopback-style count of the pulse train
    clear_mon();
    do_start(25, 7, 11);
    wait_end(1000);
    check("loop_rises", rises, 25);
    check("loop_sent", sent_cnt, 25);

`ifdef PULSE_GEN_CONTINUOUS_EN
    clear_mon();
    do_start(0, 7, 11);
    tick(989);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(3);
    check("cont_sent", sent_cnt, 55);
    check("cont_no_done", done_cnt, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 49) == 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      num_pulses  = CNT_W'($urandom_range(0, 5));
      high_cycles = WID_W'($urandom_range(0, 4));
      low_cycles  = WID_W'($urandom_range(0, 4));
      tick(1);
    end
    start = 1'b0; rst_n = 1'b1; abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
